// File: rtl/mem_ctrl_mc_pkg.sv
// Shared types and helpers for the multi-channel memory controller.
//   state_t       controller FSM states
//   CNT_W         width of the BUSY-phase latency counter (LATENCY <= 3)
//   idx_width()   word-index width for a power-of-two array depth
//   ptr_width()   channel-pointer width (at least one bit)
//   wait_bound()  worst-case cycles a held request waits for its ready pulse
package mem_ctrl_mc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  localparam int CNT_W = 2;

  function automatic int idx_width(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int ptr_width(input int n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

  // Every other channel can be served once (IDLE + LATENCY x BUSY + RESP)
  // before a held request is granted.
  function automatic int wait_bound(input int n_ch, input int latency);
    return n_ch * (latency + 2);
  endfunction

endpackage

// File: rtl/mem_ctrl_mc_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req      per-channel request bits
//   last     channel granted most recently (owned by the caller)
//   grant    first requesting channel after last, searching cyclically
//   any_req  at least one request bit is set
module rr_arbiter
  import mem_ctrl_mc_pkg::*;
#(
  parameter int N_CH = 2,
  localparam int PTR_W = ptr_width(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [PTR_W-1:0] last,
  output logic [PTR_W-1:0] grant,
  output logic             any_req
);

  int w_cand;

  // NOTE: every variable written here gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    grant   = last;
    any_req = 1'b0;
    w_cand  = 0;
    // Start one past the last grant so the last winner has lowest priority.
    for (int k = 1; k <= N_CH; k++) begin
      w_cand = (int'(last) + k) % N_CH;
      if (!any_req && req[w_cand]) begin
        grant   = PTR_W'(w_cand);
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_ctrl_mc.sv
// Multi-channel memory controller: N_CH requesters share one word array
// through valid/ready with round-robin arbitration and LATENCY BUSY cycles.
//   clk, reset   rising-edge clock, asynchronous active-high reset
//   valid        per-channel request
//   read_write   per-channel: 1 = write, 0 = read
//   address      channel i at [i*ADDR_W +: ADDR_W]
//   write_data   channel i at [i*DATA_W +: DATA_W]
//   read_data    shared read return, valid while ready[i] on a read
//   ready        one-hot one-cycle completion pulse
//   err          pulses with ready[i] for an out-of-range address
//   busy         high in BUSY and RESP
module mem_ctrl_mc
  import mem_ctrl_mc_pkg::*;
#(
  parameter int N_CH    = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 16,
  parameter int LATENCY = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_CH-1:0]          valid,
  input  logic [N_CH-1:0]          read_write,
  input  logic [N_CH*ADDR_W-1:0]   address,
  input  logic [N_CH*DATA_W-1:0]   write_data,
  output logic [DATA_W-1:0]        read_data,
  output logic [N_CH-1:0]          ready,
  output logic [N_CH-1:0]          err,
  output logic                     busy
);

  localparam int IDX_W      = idx_width(DEPTH);
  localparam int PTR_W      = ptr_width(N_CH);
  localparam int WAIT_BOUND = wait_bound(N_CH, LATENCY);

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [PTR_W-1:0]    r_last;      // round-robin pointer, doubles as current grant
  logic                r_rw;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_read_data;
  logic [N_CH-1:0]     r_ready;
  logic [N_CH-1:0]     r_err;
  logic                r_busy;
  logic [DEPTH-1:0]    r_vbit;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic [PTR_W-1:0]    w_g;
  logic                w_any;
  logic                w_acc_rw;
  logic [ADDR_W-1:0]   w_acc_addr;
  logic [PTR_W-1:0]    w_acc_g;
  logic [IDX_W-1:0]    w_acc_idx;
  logic                w_acc_oor;
  logic [N_CH-1:0]     w_acc_onehot;
  logic [DATA_W-1:0]   w_nxt_rd;

  rr_arbiter #(.N_CH(N_CH)) u_arb (
    .req     (valid),
    .last    (r_last),
    .grant   (w_g),
    .any_req (w_any)
  );

  // With LATENCY=0 the response is formed at the grant edge, before the
  // request is latched, so the access fields come straight from the winner.
  always_comb begin
    if (r_state == IDLE) begin
      w_acc_g    = w_g;
      w_acc_rw   = read_write[w_g];
      w_acc_addr = address[int'(w_g)*ADDR_W +: ADDR_W];
    end else begin
      w_acc_g    = r_last;
      w_acc_rw   = r_rw;
      w_acc_addr = r_addr;
    end
    w_acc_idx             = w_acc_addr[IDX_W-1:0];
    w_acc_oor             = |(w_acc_addr >> IDX_W);
    w_acc_onehot          = '0;
    w_acc_onehot[w_acc_g] = 1'b1;
    // Never-written words read as zero rather than stale array contents.
    w_nxt_rd              = '0;
    if (!w_acc_rw && !w_acc_oor && r_vbit[w_acc_idx]) begin
      w_nxt_rd = r_mem[w_acc_idx];
    end
  end

  // NOTE: all state is assigned with <= so every register samples the
  // pre-edge values and the update order inside the block cannot matter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_last      <= PTR_W'(N_CH - 1);
      r_rw        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_read_data <= '0;
      r_ready     <= '0;
      r_err       <= '0;
      r_busy      <= 1'b0;
      r_vbit      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_last  <= w_g;
            r_rw    <= read_write[w_g];
            r_addr  <= address[int'(w_g)*ADDR_W +: ADDR_W];
            r_wdata <= write_data[int'(w_g)*DATA_W +: DATA_W];
            r_busy  <= 1'b1;
            if (LATENCY == 0) begin
              r_state     <= RESP;
              r_ready     <= w_acc_onehot;
              r_err       <= w_acc_oor ? w_acc_onehot : '0;
              r_read_data <= w_nxt_rd;
            end else begin
              r_state <= BUSY;
              r_cnt   <= CNT_W'(LATENCY - 1);
            end
          end
        end
        BUSY: begin
          if (r_cnt == '0) begin
            r_state     <= RESP;
            r_ready     <= w_acc_onehot;
            r_err       <= w_acc_oor ? w_acc_onehot : '0;
            r_read_data <= w_nxt_rd;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        RESP: begin
          r_state     <= IDLE;
          r_ready     <= '0;
          r_err       <= '0;
          r_read_data <= '0;
          r_busy      <= 1'b0;
          if (r_rw && !w_acc_oor) begin
            r_vbit[w_acc_idx] <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // NOTE: the array has no reset; the valid bits above decide whether a
  // word holds data, so its power-up contents are never observed.
  always_ff @(posedge clk) begin
    if (r_state == RESP && r_rw && !w_acc_oor) begin
      r_mem[w_acc_idx] <= r_wdata;
    end
  end

  assign read_data = r_read_data;
  assign ready     = r_ready;
  assign err       = r_err;
  assign busy      = r_busy;

`ifndef SYNTHESIS
  a_ready_onehot0: assert property (@(posedge clk) disable iff (reset) $onehot0(ready));
  a_err_onehot0:   assert property (@(posedge clk) disable iff (reset) $onehot0(err));
  a_err_ready:     assert property (@(posedge clk) disable iff (reset) (err & ~ready) == '0);
  a_ready_pulse:   assert property (@(posedge clk) disable iff (reset) (|ready) |=> !(|ready));
  a_rd_known:      assert property (@(posedge clk) disable iff (reset) (|ready) |-> !$isunknown(read_data));

  for (genvar i = 0; i < N_CH; i++) begin : g_chan_chk
    logic [7:0] r_wait;
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_wait <= '0;
      end else if (valid[i] && !ready[i]) begin
        r_wait <= r_wait + 8'(r_wait != 8'hFF);
      end else begin
        r_wait <= '0;
      end
    end
    a_wait_bound: assert property (@(posedge clk) disable iff (reset) r_wait < 8'(WAIT_BOUND));
    a_req_stable: assume property (@(posedge clk) disable iff (reset)
      (valid[i] && !ready[i]) |=> $stable(address[i*ADDR_W +: ADDR_W]) && $stable(read_write[i]));
  end
`endif

endmodule
